// File: rtl/urv_mem_arbiter_if.sv
// rtl/urv_mem_arbiter_if.sv - fetch, data, host and RAM signal bundle for urv_mem_arbiter
interface urv_mem_arbiter_if #(
  parameter int g_addr_width = 16
);
  logic [31:0]             im_addr_i;
  logic [31:0]             im_data_o;
  logic                    im_valid_o;
  logic [31:0]             dm_addr_i;
  logic [31:0]             dm_data_s_i;
  logic [3:0]              dm_data_select_i;
  logic                    dm_load_i;
  logic                    dm_store_i;
  logic                    dm_ready_o;
  logic [31:0]             dm_data_l_o;
  logic                    dm_load_done_o;
  logic                    dm_store_done_o;
  logic                    host_req_i;
  logic                    host_we_i;
  logic [31:0]             host_addr_i;
  logic [31:0]             host_data_i;
  logic                    host_ack_o;
  logic [31:0]             host_data_o;
  logic [g_addr_width-1:0] mem_addr_o;
  logic [31:0]             mem_data_o;
  logic [3:0]              mem_be_o;
  logic                    mem_we_o;
  logic [31:0]             mem_data_i;

  modport master (
    output im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output host_req_i, host_we_i, host_addr_i, host_data_i, mem_data_i,
    input  im_data_o, im_valid_o, dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    input  host_ack_o, host_data_o, mem_addr_o, mem_data_o, mem_be_o, mem_we_o
  );

  modport slave (
    input  im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  host_req_i, host_we_i, host_addr_i, host_data_i, mem_data_i,
    output im_data_o, im_valid_o, dm_ready_o, dm_data_l_o, dm_load_done_o, dm_store_done_o,
    output host_ack_o, host_data_o, mem_addr_o, mem_data_o, mem_be_o, mem_we_o
  );
endinterface

// File: rtl/urv_mem_arbiter.sv
// rtl/urv_mem_arbiter.sv - single-port RAM arbiter: data > host > fetch, with fetch starvation guard
module urv_mem_arbiter #(
  parameter int g_mem_words          = 65536,
  parameter int g_addr_width         = 16,
  parameter int g_fetch_starve_limit = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  urv_mem_arbiter_if.slave        bus
);
  localparam int AW = g_addr_width;
  localparam logic [AW-1:0] ADDR_MASK = AW'(g_mem_words - 1);
  localparam logic [3:0]    LIMIT     = 4'(g_fetch_starve_limit);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE, S_HOST} state_t;

  state_t          last_q, grant;
  logic [3:0]      starve_cnt;
  logic            ready_q;
  logic            pend_valid, pend_we;
  logic [AW-1:0]   pend_addr, fetch_word_q;
  logic [31:0]     pend_data;
  logic [3:0]      pend_be;

  logic            new_acc, data_req, d_we;
  logic [AW-1:0]   d_addr, m_addr;
  logic [31:0]     d_data, m_data;
  logic [3:0]      d_be, m_be;
  logic            m_we;

  function automatic logic [AW-1:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[AW+1:2] & ADDR_MASK;
  endfunction

  always_comb begin
    new_acc  = ready_q & (bus.dm_load_i | bus.dm_store_i);
    data_req = new_acc | pend_valid;
    // a simultaneous load is dropped: dm_store_i alone decides the direction
    d_we     = pend_valid ? pend_we   : bus.dm_store_i;
    d_addr   = pend_valid ? pend_addr : word_of(bus.dm_addr_i);
    d_data   = pend_valid ? pend_data : bus.dm_data_s_i;
    d_be     = pend_valid ? pend_be   : (bus.dm_store_i ? bus.dm_data_select_i : 4'hF);

    grant = S_FETCH;
    if (starve_cnt == LIMIT)                        grant = S_FETCH;
    else if (data_req)                              grant = d_we ? S_STORE : S_LOAD;
    else if (bus.host_req_i && last_q != S_HOST)    grant = S_HOST;

    m_addr = word_of(bus.im_addr_i);
    m_data = '0;
    m_be   = 4'hF;
    m_we   = 1'b0;
    case (grant)
      S_LOAD, S_STORE: begin
        m_addr = d_addr;
        m_data = d_data;
        m_be   = d_be;
        m_we   = d_we;
      end
      S_HOST: begin
        m_addr = word_of(bus.host_addr_i);
        m_data = bus.host_data_i;
        m_we   = bus.host_we_i;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr_o = rst_i ? '0 : m_addr;
  assign bus.mem_data_o = rst_i ? '0 : m_data;
  assign bus.mem_be_o   = rst_i ? '0 : m_be;
  assign bus.mem_we_o   = rst_i ? 1'b0 : m_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q       <= S_IDLE;
      starve_cnt   <= '0;
      ready_q      <= 1'b1;
      pend_valid   <= 1'b0;
      pend_we      <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      pend_be      <= '0;
      fetch_word_q <= '0;
    end else begin
      last_q <= grant;
      if (grant == S_FETCH) begin
        starve_cnt   <= '0;
        fetch_word_q <= word_of(bus.im_addr_i);
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      // an accepted pulse that lost to a forced fetch waits here for the next cycle
      if (grant == S_LOAD || grant == S_STORE) begin
        pend_valid <= 1'b0;
      end else if (new_acc) begin
        pend_valid <= 1'b1;
        pend_we    <= d_we;
        pend_addr  <= d_addr;
        pend_data  <= d_data;
        pend_be    <= d_be;
      end
      ready_q <= !(data_req && grant != S_LOAD && grant != S_STORE);
    end
  end

  assign bus.dm_ready_o      = ready_q;
  assign bus.dm_load_done_o  = (last_q == S_LOAD);
  assign bus.dm_store_done_o = (last_q == S_STORE);
  assign bus.dm_data_l_o     = bus.dm_load_done_o ? bus.mem_data_i : '0;
  assign bus.host_ack_o      = (last_q == S_HOST);
  assign bus.host_data_o     = bus.host_ack_o ? bus.mem_data_i : '0;
  assign bus.im_valid_o      = (last_q == S_FETCH) && (word_of(bus.im_addr_i) == fetch_word_q);
  assign bus.im_data_o       = bus.im_valid_o ? bus.mem_data_i : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.im_addr_i[31:AW+2], bus.im_addr_i[1:0],
                              bus.dm_addr_i[31:AW+2], bus.dm_addr_i[1:0],
                              bus.host_addr_i[31:AW+2], bus.host_addr_i[1:0]};
endmodule

// File: tb/tb_urv_mem_arbiter.sv
// tb/tb_urv_mem_arbiter.sv - directed self-checking bench for urv_mem_arbiter
module tb_urv_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] ram [0:65535];
  logic prev_fetch;

  always #5 clk = ~clk;

  urv_mem_arbiter_if #(.g_addr_width(16)) bus ();

  urv_mem_arbiter #(
    .g_mem_words(65536),
    .g_addr_width(16),
    .g_fetch_starve_limit(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be_o[b]) ram[bus.mem_addr_o][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
    end
    bus.mem_data_i <= ram[bus.mem_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    ram[16'h0040] = 32'h0000_0013;
    ram[16'h0002] = 32'h1234_5678;
    ram[16'h00C0] = 32'hCAFE_0001;
    bus.mem_data_i       = 32'h0;
    bus.im_addr_i        = 32'h100;
    bus.dm_addr_i        = 32'h0;
    bus.dm_data_s_i      = 32'h0;
    bus.dm_data_select_i = 4'h0;
    bus.dm_load_i        = 1'b0;
    bus.dm_store_i       = 1'b0;
    bus.host_req_i       = 1'b0;
    bus.host_we_i        = 1'b0;
    bus.host_addr_i      = 32'h0;
    bus.host_data_i      = 32'h0;

    next_cycle();
    settle();
    chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_dm_ready", 32'(bus.dm_ready_o), 32'h1);
    chk("rst_im_valid", 32'(bus.im_valid_o), 32'h0);
    chk("rst_done", 32'({bus.dm_load_done_o, bus.dm_store_done_o, bus.host_ack_o}), 32'h0);

    next_cycle(); rst = 1'b0;
    settle();
    chk("idle1_addr", 32'(bus.mem_addr_o), 32'h40);
    chk("idle1_be", 32'(bus.mem_be_o), 32'hF);
    chk("idle1_valid", 32'(bus.im_valid_o), 32'h0);
    next_cycle();
    settle();
    chk("idle2_addr", 32'(bus.mem_addr_o), 32'h40);
    chk("idle2_valid", 32'(bus.im_valid_o), 32'h1);
    chk("idle2_data", bus.im_data_o, 32'h13);

    next_cycle();
    bus.dm_addr_i = 32'h204; bus.dm_data_s_i = 32'hDEADBEEF; bus.dm_data_select_i = 4'b0011;
    bus.dm_store_i = 1'b1;
    settle();
    chk("st_we", 32'(bus.mem_we_o), 32'h1);
    chk("st_addr", 32'(bus.mem_addr_o), 32'h81);
    chk("st_be", 32'(bus.mem_be_o), 32'h3);
    chk("st_data", bus.mem_data_o, 32'hDEADBEEF);
    next_cycle(); bus.dm_store_i = 1'b0;
    settle();
    chk("st_done", 32'(bus.dm_store_done_o), 32'h1);
    chk("st_im_valid", 32'(bus.im_valid_o), 32'h0);
    chk("st_ready", 32'(bus.dm_ready_o), 32'h1);
    next_cycle(); bus.dm_load_i = 1'b1;
    settle();
    chk("ld_we", 32'(bus.mem_we_o), 32'h0);
    chk("ld_addr", 32'(bus.mem_addr_o), 32'h81);
    next_cycle(); bus.dm_load_i = 1'b0;
    settle();
    chk("ld_done", 32'(bus.dm_load_done_o), 32'h1);
    chk("ld_data", bus.dm_data_l_o, 32'h0000BEEF);

    // host read of word 2 held against six back-to-back load pulses
    next_cycle();
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b0; bus.host_addr_i = 32'h8;
    bus.dm_load_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      settle();
      if (c == 5) chk("hs_forced_fetch", 32'(bus.mem_addr_o), 32'h40);
      else        chk("hs_data_addr", 32'(bus.mem_addr_o), 32'h81);
      chk("hs_no_ack", 32'(bus.host_ack_o), 32'h0);
      if (c == 6) begin
        chk("hs_ready_pending", 32'(bus.dm_ready_o), 32'h0);
        chk("hs_fetch_valid", 32'(bus.im_valid_o), 32'h1);
        chk("hs_no_done_after_fetch", 32'(bus.dm_load_done_o), 32'h0);
      end
      next_cycle();
    end
    bus.dm_load_i = 1'b0;
    settle();
    chk("hs_grant_addr", 32'(bus.mem_addr_o), 32'h2);
    chk("hs_pend_done", 32'(bus.dm_load_done_o), 32'h1);
    chk("hs_ack_early", 32'(bus.host_ack_o), 32'h0);
    next_cycle(); bus.host_req_i = 1'b0;
    settle();
    chk("hs_ack", 32'(bus.host_ack_o), 32'h1);
    chk("hs_rdata", bus.host_data_o, 32'h12345678);
    chk("hs_after_fetch", 32'(bus.mem_addr_o), 32'h40);

    // continuous stores: fetch every fifth cycle
    prev_fetch = 1'b1;
    next_cycle();
    bus.dm_addr_i = 32'h400; bus.dm_data_s_i = 32'h5555AAAA; bus.dm_data_select_i = 4'hF;
    bus.dm_store_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("stream_we", 32'(bus.mem_we_o), (i % 5 == 4) ? 32'h0 : 32'h1);
      chk("stream_im_valid", 32'(bus.im_valid_o), 32'(prev_fetch));
      prev_fetch = (i % 5 == 4);
      next_cycle();
    end
    bus.dm_store_i = 1'b0;
    settle();
    chk("stream_ram", ram[16'h100], 32'h5555AAAA);

    // host writes held continuously: one ack cycle between grants
    next_cycle();
    bus.host_req_i = 1'b1; bus.host_we_i = 1'b1; bus.host_addr_i = 32'hC; bus.host_data_i = 32'hA5A5A5A5;
    settle();
    chk("hw1_we", 32'(bus.mem_we_o), 32'h1);
    chk("hw1_addr", 32'(bus.mem_addr_o), 32'h3);
    next_cycle();
    settle();
    chk("hw2_ack", 32'(bus.host_ack_o), 32'h1);
    chk("hw2_fetch", 32'(bus.mem_we_o), 32'h0);
    next_cycle();
    settle();
    chk("hw3_regrant", 32'(bus.mem_we_o), 32'h1);
    chk("hw3_no_ack", 32'(bus.host_ack_o), 32'h0);
    next_cycle(); bus.host_req_i = 1'b0;
    settle();
    chk("hw4_ack", 32'(bus.host_ack_o), 32'h1);
    chk("hw_ram", ram[3], 32'hA5A5A5A5);

    // branch right after a fetch grant
    next_cycle();
    settle();
    chk("br_fetch", 32'(bus.mem_addr_o), 32'h40);
    next_cycle(); bus.im_addr_i = 32'h300;
    settle();
    chk("br_stale", 32'(bus.im_valid_o), 32'h0);
    chk("br_addr", 32'(bus.mem_addr_o), 32'hC0);
    next_cycle();
    settle();
    chk("br_valid", 32'(bus.im_valid_o), 32'h1);
    chk("br_data", bus.im_data_o, 32'hCAFE0001);

    // load and store together: store only
    next_cycle();
    bus.dm_addr_i = 32'h10; bus.dm_data_s_i = 32'h11223344; bus.dm_data_select_i = 4'hF;
    bus.dm_load_i = 1'b1; bus.dm_store_i = 1'b1;
    settle();
    chk("ls_we", 32'(bus.mem_we_o), 32'h1);
    next_cycle(); bus.dm_load_i = 1'b0; bus.dm_store_i = 1'b0;
    settle();
    chk("ls_store_done", 32'(bus.dm_store_done_o), 32'h1);
    chk("ls_load_done", 32'(bus.dm_load_done_o), 32'h0);
    chk("ls_ram", ram[4], 32'h11223344);

    // reset in the grant cycle
    next_cycle();
    bus.dm_addr_i = 32'h20; bus.dm_store_i = 1'b1; rst = 1'b1;
    settle();
    next_cycle(); bus.dm_store_i = 1'b0; rst = 1'b0;
    settle();
    chk("rg_no_done", 32'(bus.dm_store_done_o), 32'h0);
    chk("rg_ready", 32'(bus.dm_ready_o), 32'h1);
    chk("rg_im_valid", 32'(bus.im_valid_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
